// File: rtl/bit_count_unit.sv
`timescale 1ns/1ps
// Two-stage pipelined CLZ / CTZ / CPOP unit with valid/ready handshakes on both sides.
// S1 turns every op into "count trailing zeros" or "count ones" per 8-bit group; S2 combines the groups.
module bit_count_unit #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 6,
    localparam int RW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic             in_word,
    input  logic [WIDTH-1:0] in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic             busy
);

    localparam int NG = WIDTH / 8;

    typedef enum logic [1:0] {
        OP_CLZ  = 2'b00,
        OP_CTZ  = 2'b01,
        OP_CPOP = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    op_e              opIn;
    logic             wordMode;
    logic [WIDTH-1:0] masked;
    logic [WIDTH-1:0] scan;
    logic [7:0]       grp;
    logic [3:0]       grpPop_d [NG];
    logic [3:0]       grpTz_d  [NG];
    logic             grpNz_d  [NG];

    logic             s1Valid_q;
    logic [TAG_W-1:0] s1Tag_q;
    logic             s1Illegal_q;
    logic             s1IsPop_q;
    logic             s1Ew32_q;
    logic [3:0]       s1GrpPop_q [NG];
    logic [3:0]       s1GrpTz_q  [NG];
    logic             s1GrpNz_q  [NG];

    logic             s2Valid_q;
    logic [RW-1:0]    s2Cnt_q;
    logic [TAG_W-1:0] s2Tag_q;
    logic             s2Illegal_q;

    logic             inFire;
    logic             outFire;
    logic             s2Load;
    logic             s1Valid_d;
    logic             s2Valid_d;
    logic [RW-1:0]    popSum;
    logic [RW-1:0]    firstSet;
    logic [RW-1:0]    s2Cnt_d;

    // Handshake: S2 frees up when it transfers out; S1 frees up when it moves into S2.
    always_comb begin
        outFire   = s2Valid_q && out_ready && !flush;
        s2Load    = !flush && s1Valid_q && (!s2Valid_q || outFire);
        in_ready  = !flush && (!s1Valid_q || s2Load);
        inFire    = in_valid && in_ready;
        s1Valid_d = s1Valid_q;
        s2Valid_d = s2Valid_q;
        if (flush) begin
            s1Valid_d = 1'b0;
            s2Valid_d = 1'b0;
        end else begin
            if (!s1Valid_q || s2Load) begin
                s1Valid_d = in_valid;
            end
            if (s2Load) begin
                s2Valid_d = 1'b1;
            end else if (outFire) begin
                s2Valid_d = 1'b0;
            end
        end
    end

    // CLZ is computed as CTZ of the bit-reversed effective operand, so S2 only needs one scan.
    always_comb begin
        opIn     = op_e'(in_op);
        wordMode = (WIDTH == 64) && in_word;
        masked   = '0;
        scan     = '0;
        grp      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            masked[i] = (wordMode && i >= 32) ? 1'b0 : in_data[i];
        end
        if (opIn == OP_CLZ) begin
            if (wordMode) begin
                for (int i = 0; i < 32; i++) begin
                    scan[i] = in_data[31-i];
                end
            end else begin
                for (int i = 0; i < WIDTH; i++) begin
                    scan[i] = in_data[WIDTH-1-i];
                end
            end
        end else begin
            scan = masked;
        end
        for (int g = 0; g < NG; g++) begin
            grp         = scan[g*8 +: 8];
            grpPop_d[g] = '0;
            grpTz_d[g]  = '0;
            grpNz_d[g]  = |grp;
            for (int k = 0; k < 8; k++) begin
                grpPop_d[g] = grpPop_d[g] + 4'(grp[k]);
            end
            for (int k = 7; k >= 0; k--) begin
                if (grp[k]) begin
                    grpTz_d[g] = 4'(k);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid_q   <= 1'b0;
            s1Tag_q     <= '0;
            s1Illegal_q <= 1'b0;
            s1IsPop_q   <= 1'b0;
            s1Ew32_q    <= 1'b0;
            for (int g = 0; g < NG; g++) begin
                s1GrpPop_q[g] <= '0;
                s1GrpTz_q[g]  <= '0;
                s1GrpNz_q[g]  <= 1'b0;
            end
        end else begin
            s1Valid_q <= s1Valid_d;
            if (inFire) begin
                s1Tag_q     <= in_tag;
                s1Illegal_q <= (opIn == OP_RSVD);
                s1IsPop_q   <= (opIn == OP_CPOP);
                s1Ew32_q    <= wordMode;
                for (int g = 0; g < NG; g++) begin
                    s1GrpPop_q[g] <= grpPop_d[g];
                    s1GrpTz_q[g]  <= grpTz_d[g];
                    s1GrpNz_q[g]  <= grpNz_d[g];
                end
            end
        end
    end

    // The lowest non-empty group wins; an all-zero operand falls through to the effective width.
    always_comb begin
        popSum   = '0;
        firstSet = s1Ew32_q ? RW'(32) : RW'(WIDTH);
        for (int g = 0; g < NG; g++) begin
            popSum = popSum + RW'(s1GrpPop_q[g]);
        end
        for (int g = NG - 1; g >= 0; g--) begin
            if (s1GrpNz_q[g]) begin
                firstSet = RW'(g * 8) + RW'(s1GrpTz_q[g]);
            end
        end
        if (s1Illegal_q) begin
            s2Cnt_d = '0;
        end else if (s1IsPop_q) begin
            s2Cnt_d = popSum;
        end else begin
            s2Cnt_d = firstSet;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2Valid_q   <= 1'b0;
            s2Cnt_q     <= '0;
            s2Tag_q     <= '0;
            s2Illegal_q <= 1'b0;
        end else begin
            s2Valid_q <= s2Valid_d;
            if (s2Load) begin
                s2Cnt_q     <= s2Cnt_d;
                s2Tag_q     <= s1Tag_q;
                s2Illegal_q <= s1Illegal_q;
            end
        end
    end

    assign out_valid   = s2Valid_q;
    assign out_data    = {{(WIDTH - RW){1'b0}}, s2Cnt_q};
    assign out_tag     = s2Tag_q;
    assign out_illegal = s2Illegal_q;
    assign busy        = s1Valid_q || s2Valid_q;

endmodule

// File: tb/tb_bit_count_unit.sv
`timescale 1ns/1ps
// Directed self-checking bench for bit_count_unit (WIDTH=64, TAG_W=6).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bit_count_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic        in_word;
    logic [63:0] in_data;
    logic [5:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [5:0]  out_tag;
    logic        out_illegal;
    logic        busy;

    int assertCount = 0;
    int failCount   = 0;

    bit_count_unit #(.WIDTH(64), .TAG_W(6)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_word(in_word),
        .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_illegal(out_illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    // Offers one op to an idle unit and waits (bounded) for its result; lat counts edges after acceptance.
    task automatic runOp(input logic [1:0] op, input logic word, input logic [63:0] data,
                         input logic [5:0] tag, output logic [63:0] resData,
                         output logic [5:0] resTag, output logic resIll, output int lat);
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_word = word; in_data = data; in_tag = tag;
        @(negedge clk);
        in_valid = 1'b0;
        resData = '1; resTag = '1; resIll = 1'bx; lat = -1;
        for (int k = 0; k < 8; k++) begin
            if (out_valid) begin
                resData = out_data; resTag = out_tag; resIll = out_illegal; lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        assertCount++; if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        assertCount++; if (out_data !== 64'd0) begin failCount++; $display("[TB] FAIL reset_out_data: got %h want 0", out_data); end
        assertCount++; if (out_tag !== 6'd0) begin failCount++; $display("[TB] FAIL reset_out_tag: got %0d want 0", out_tag); end
        assertCount++; if (out_illegal !== 1'b0) begin failCount++; $display("[TB] FAIL reset_out_illegal: got %b want 0", out_illegal); end
        rst = 1'b0;
        @(negedge clk);
        assertCount++; if (in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    // Shared vector runner for the three counting ops: checks count, tag, illegal flag and latency.
    task automatic runTable(input string name, input logic [1:0] op, input logic [63:0] dataTab [6],
                            input logic wordTab [6], input logic [63:0] expTab [6]);
        logic [63:0] d; logic [5:0] t; logic il; int lat;
        for (int i = 0; i < 6; i++) begin
            runOp(op, wordTab[i], dataTab[i], 6'(i + 10), d, t, il, lat);
            assertCount++; if (d !== expTab[i]) begin failCount++; $display("[TB] FAIL %s_%0d data: got %0d want %0d (operand %h word %b)", name, i, d, expTab[i], dataTab[i], wordTab[i]); end
            assertCount++; if (t !== 6'(i + 10)) begin failCount++; $display("[TB] FAIL %s_%0d tag: got %0d want %0d", name, i, t, i + 10); end
            assertCount++; if (il !== 1'b0) begin failCount++; $display("[TB] FAIL %s_%0d illegal: got %b want 0", name, i, il); end
            assertCount++; if (lat !== 1) begin failCount++; $display("[TB] FAIL %s_%0d latency: got %0d want 1", name, i, lat); end
        end
    endtask

    task automatic test_clz;
        logic [63:0] dataTab [6] = '{64'h1, 64'h0, 64'h8000_0000_0000_0000, 64'h1, 64'hFFFF_FFFF_0000_0100, 64'h0000_0000_0001_0000};
        logic        wordTab [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [63:0] expTab  [6] = '{64'd63, 64'd64, 64'd0, 64'd31, 64'd23, 64'd47};
        runTable("clz", 2'b00, dataTab, wordTab, expTab);
    endtask

    task automatic test_ctz;
        logic [63:0] dataTab [6] = '{64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000, 64'h80, 64'h0, 64'h8000_0000_0000_0000, 64'h0};
        logic        wordTab [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [63:0] expTab  [6] = '{64'd32, 64'd32, 64'd7, 64'd64, 64'd63, 64'd32};
        runTable("ctz", 2'b01, dataTab, wordTab, expTab);
    endtask

    task automatic test_cpop;
        logic [63:0] dataTab [6] = '{64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0F0F_0F0F_0F0F_0F0F, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0};
        logic        wordTab [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [63:0] expTab  [6] = '{64'd0, 64'd32, 64'd64, 64'd32, 64'd32, 64'd32};
        runTable("cpop", 2'b10, dataTab, wordTab, expTab);
    endtask

    task automatic test_illegal;
        logic [63:0] d; logic [5:0] t; logic il; int lat;
        runOp(2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 6'd5, d, t, il, lat);
        assertCount++; if (d !== 64'd0) begin failCount++; $display("[TB] FAIL illegal_data: got %0d want 0", d); end
        assertCount++; if (il !== 1'b1) begin failCount++; $display("[TB] FAIL illegal_flag: got %b want 1", il); end
        assertCount++; if (t !== 6'd5) begin failCount++; $display("[TB] FAIL illegal_tag: got %0d want 5", t); end
        runOp(2'b10, 1'b0, 64'hF, 6'd6, d, t, il, lat);
        assertCount++; if (d !== 64'd4) begin failCount++; $display("[TB] FAIL after_illegal_data: got %0d want 4", d); end
        assertCount++; if (il !== 1'b0) begin failCount++; $display("[TB] FAIL after_illegal_flag: got %b want 0", il); end
        assertCount++; if (t !== 6'd6) begin failCount++; $display("[TB] FAIL after_illegal_tag: got %0d want 6", t); end
    endtask

    // Eight CPOP ops with popcount i and tag i, one per cycle; results must come out with no gaps.
    task automatic test_back_to_back;
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    in_valid = 1'b1; in_op = 2'b10; in_word = 1'b0;
                    in_data = (64'd1 << i) - 64'd1; in_tag = 6'(i);
                    assertCount++; if (in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_in_ready_%0d: got %b want 1", i, in_ready); end
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                int waited;
                waited = 0;
                @(negedge clk);
                while (!out_valid && waited < 10) begin
                    @(negedge clk);
                    waited++;
                end
                for (int i = 0; i < 8; i++) begin
                    assertCount++; if (out_valid !== 1'b1 || out_tag !== 6'(i) || out_data !== 64'(i)) begin
                        failCount++; $display("[TB] FAIL b2b_result_%0d: valid %b tag %0d data %0d want valid 1 tag %0d data %0d", i, out_valid, out_tag, out_data, i, i);
                    end
                    @(negedge clk);
                end
            end
        join
        @(negedge clk);
        assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_drained_busy: got %b want 0", busy); end
    endtask

    task automatic test_stall;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 2'b10; in_word = 1'b0; in_data = 64'hFF; in_tag = 6'd8;
        @(negedge clk);
        assertCount++; if (in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL stall_second_ready: got %b want 1", in_ready); end
        in_data = 64'h1; in_tag = 6'd9;
        @(negedge clk);
        in_data = 64'h3; in_tag = 6'd10;
        for (int c = 0; c < 5; c++) begin
            assertCount++; if (out_valid !== 1'b1 || out_tag !== 6'd8 || out_data !== 64'd8 || out_illegal !== 1'b0) begin
                failCount++; $display("[TB] FAIL stall_hold_%0d: valid %b tag %0d data %0d illegal %b want 1 8 8 0", c, out_valid, out_tag, out_data, out_illegal);
            end
            assertCount++; if (in_ready !== 1'b0 || busy !== 1'b1) begin
                failCount++; $display("[TB] FAIL stall_ready_%0d: in_ready %b busy %b want 0 1", c, in_ready, busy);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        assertCount++; if (out_valid !== 1'b1 || out_tag !== 6'd9 || out_data !== 64'd1) begin
            failCount++; $display("[TB] FAIL stall_release: valid %b tag %0d data %0d want 1 9 1", out_valid, out_tag, out_data);
        end
        @(negedge clk);
        assertCount++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failCount++; $display("[TB] FAIL stall_drain: valid %b busy %b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_flush;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b00; in_word = 1'b0; in_data = 64'h1; in_tag = 6'd1;
        @(negedge clk);
        in_data = 64'h2; in_tag = 6'd2;
        @(negedge clk);
        assertCount++; if (out_valid !== 1'b1 || out_tag !== 6'd1 || busy !== 1'b1) begin
            failCount++; $display("[TB] FAIL flush_pre: valid %b tag %0d busy %b want 1 1 1", out_valid, out_tag, busy);
        end
        flush = 1'b1;
        in_data = 64'h4; in_tag = 6'd3;
        #1;
        assertCount++; if (in_ready !== 1'b0) begin failCount++; $display("[TB] FAIL flush_in_ready: got %b want 0", in_ready); end
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        assertCount++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failCount++; $display("[TB] FAIL flush_after: valid %b busy %b want 0 0", out_valid, busy);
        end
        repeat (2) @(negedge clk);
        assertCount++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failCount++; $display("[TB] FAIL flush_nothing_left: valid %b busy %b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 2'b10; in_word = 1'b0; in_data = 64'h7; in_tag = 6'd7;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        assertCount++; if (out_valid !== 1'b1 || out_data !== 64'd3) begin
            failCount++; $display("[TB] FAIL areset_pre: valid %b data %0d want 1 3", out_valid, out_data);
        end
        #2;
        rst = 1'b1;
        #1;
        assertCount++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 64'd0 || out_tag !== 6'd0) begin
            failCount++; $display("[TB] FAIL areset_immediate: valid %b busy %b data %0d tag %0d want 0 0 0 0", out_valid, busy, out_data, out_tag);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        assertCount++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failCount++; $display("[TB] FAIL areset_release: in_ready %b valid %b want 1 0", in_ready, out_valid);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_word = 1'b0;
        in_data = '0; in_tag = '0; out_ready = 1'b1;
        test_reset();
        test_clz();
        test_ctz();
        test_cpop();
        test_illegal();
        test_back_to_back();
        test_stall();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/bit_count_unit.md
BIT_COUNT_UNIT -- requirements
Module: bit_count_unit

Interface
REQ-001 Parameter WIDTH, default 64, operand width; legal values 32 and 64.
REQ-002 Parameter TAG_W, default 6, width of the opaque tag carried with each operation.
REQ-003 Parameter RW, derived as $clog2(WIDTH)+1, internal count width; not overridable.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  kill all in-flight operations.
REQ-007 in_valid  input  1  operation offered.
REQ-008 in_ready  output  1  unit can accept an operation this cycle.
REQ-009 in_op  input  2  00 CLZ, 01 CTZ, 10 CPOP, 11 reserved.
REQ-010 in_word  input  1  operate on bits [31:0] only; ignored when WIDTH=32.
REQ-011 in_data  input  WIDTH  operand.
REQ-012 in_tag  input  TAG_W  tag returned with the result.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  consumer accepts the result.
REQ-015 out_data  output  WIDTH  count, zero-extended to WIDTH.
REQ-016 out_tag  output  TAG_W  tag of the operation producing out_data.
REQ-017 out_illegal  output  1  operation used in_op=11.
REQ-018 busy  output  1  high while any pipeline stage holds a valid entry.

Function
REQ-019 Transfer on input when in_valid && in_ready at a rising edge; on output when out_valid && out_ready.
REQ-020 Two-stage pipeline S1, S2; S2 drives the outputs directly from registers.
- S1: masked/bit-reversed operand, per-group counts.
- S2: final count.
REQ-021 Latency: an operation accepted at edge N has out_valid=1 after edge N+1 (visible in the cycle following edge N+1) when not stalled.
REQ-022 Throughput: one operation per cycle while out_ready=1.
REQ-023 S2 loads from S1 when S2 is empty or S2 transfers out this cycle.
REQ-024 S1 loads when S1 is empty or S1 advances this cycle.
REQ-025 in_ready = !flush && (!S1.valid || S1 advances).
REQ-026 While out_valid=1 and out_ready=0: out_data, out_tag and out_illegal hold stable and S2 is not overwritten.
REQ-027 Effective operand: in_data[31:0] when in_word=1 and WIDTH=64; otherwise in_data. Effective width EW = 32 or WIDTH accordingly.
REQ-028 CLZ: number of zero bits above the highest set bit of the effective operand; equals EW when the operand is zero.
REQ-029 CTZ: number of zero bits below the lowest set bit; equals EW when the operand is zero.
REQ-030 CPOP: number of set bits in the effective operand, 0..EW.
REQ-031 Reserved op (11): out_data=0 and out_illegal=1; the pipeline otherwise treats it as a normal operation.
REQ-032 Upper bits of out_data above RW are always 0.
REQ-033 flush=1 at an edge clears S1.valid and S2.valid at that edge; a result presented in the same cycle is not transferred, regardless of out_ready.
REQ-034 Flush and in_valid in the same cycle: the input is not accepted (in_ready=0).
REQ-035 busy = S1.valid || S2.valid.

Reset
REQ-036 During rst: S1.valid=0, S2.valid=0, out_valid=0, out_data=0, out_tag=0, out_illegal=0, busy=0.
REQ-037 in_ready=1 after rst deasserts.
REQ-038 rst asserted mid-operation discards all in-flight entries with no output transfer.

Verification
REQ-039 WIDTH=64, CLZ, in_data=0x0000_0000_0000_0001 -> out_data=63, two cycles after acceptance; in_data=0 -> out_data=64.
REQ-040 WIDTH=64, in_word=1, CTZ, in_data=0xFFFF_FFFF_0000_0000 -> out_data=32. Same operand with CPOP, in_word=1 -> out_data=0; in_word=0 -> out_data=32.
REQ-041 Back-to-back: 8 ops with tags 0..7 and out_ready=1 -> 8 consecutive results in order with matching tags. Then out_ready=0 for 5 cycles -> at most 2 entries held, in_ready=0, outputs stable until out_ready returns.
REQ-042 Two ops in flight, flush pulsed for 1 cycle with out_valid=1 and out_ready=1 -> no transfer; busy=0 and out_valid=0 on the next cycle.
REQ-043 in_op=11, in_tag=5 -> out_data=0, out_illegal=1, out_tag=5; the next legal op has out_illegal=0.
REQ-044 rst asserted asynchronously between edges with S2 full -> out_valid=0 immediately, without waiting for a clock edge; in_ready=1 after release.
